mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port 16x4 register memory.
- Port 0 is the CPU core (instruction fetch and LD/ST data).
- Port 1 is the external program loader/debug port.
- Grants at most one access per cycle, round-robin on contention, with a lock for uninterrupted loader bursts. Read data is registered and returned one cycle after the grant.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/rr_grant2.sv | 22 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port register-memory arbiter.
package mem_arbiter_pkg;

  // Ownership state of the arbiter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Requester indices, also used as the encoding of last_gnt.
  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin picker: one-hot grant, the port that
// did not win last time takes a tie.
module rr_grant2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  // Single requester wins outright; a tie goes to the port != last_gnt.
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o = last_gnt_i ? 2'b01 : 2'b10;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port register memory between the CPU core
// (port 0) and the program loader/debug port (port 1).
//
// Handshake: a requester raises req with we/addr/wdata and holds them
// stable until it sees gnt in the same cycle; gnt means the access was
// performed this cycle (no buffering). A granted read returns its data
// with rvalid high for exactly the following cycle; writes have no rvalid.
// While a port owns the arbiter through lock, the other port sees no grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic                  lock0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic                  lock1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [1:0]            dbg_state_o
);

  arb_state_e state_q;
  logic       last_gnt_q;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;

  rr_grant2 u_rr_grant2 (
    .req0_i     (req0_i),
    .req1_i     (req1_i),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (rr_gnt)
  );

  // Grant selection: round-robin when idle, owner-only when locked,
  // nothing at all while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (reset_ni) begin
      case (state_q)
        IDLE:    gnt = rr_gnt;
        OWN0:    gnt = {1'b0, req0_i};
        OWN1:    gnt = {req1_i, 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt0_o      = gnt[0];
  assign gnt1_o      = gnt[1];
  assign dbg_state_o = state_q;

  // Memory-side mux: drive the granted port's access, all zero otherwise.
  always_comb begin
    mem_write_en_o = 1'b0;
    mem_read_en_o  = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    if (gnt[0]) begin
      mem_write_en_o = we0_i;
      mem_read_en_o  = ~we0_i;
      mem_addr_o     = addr0_i;
      mem_data_o     = wdata0_i;
    end else if (gnt[1]) begin
      mem_write_en_o = we1_i;
      mem_read_en_o  = ~we1_i;
      mem_addr_o     = addr1_i;
      mem_data_o     = wdata1_i;
    end
  end

  // Ownership FSM and round-robin history; an owner that drops lock while
  // idle releases the arbiter without needing another access.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= PORT_LOADER;
    end else if (gnt[0]) begin
      last_gnt_q <= PORT_CPU;
      state_q    <= lock0_i ? OWN0 : IDLE;
    end else if (gnt[1]) begin
      last_gnt_q <= PORT_LOADER;
      state_q    <= lock1_i ? OWN1 : IDLE;
    end else if ((state_q == OWN0) && !lock0_i) begin
      state_q <= IDLE;
    end else if ((state_q == OWN1) && !lock1_i) begin
      state_q <= IDLE;
    end
  end

  // Read return: capture memory data at the end of a granted read; rdata
  // holds until that port's next read.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
    end else begin
      rvalid0_o <= gnt[0] & ~we0_i;
      rvalid1_o <= gnt[1] & ~we1_i;
      if (gnt[0] && !we0_i) rdata0_o <= mem_data_i;
      if (gnt[1] && !we1_i) rdata1_o <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench models the register memory itself and
// keeps an abstract reference (owner / last winner / reference memory).
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req, we, lock;
  logic [3:0] addr [2];
  logic [3:0] wdata [2];
  logic       gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [3:0] rdata0_o, rdata1_o;
  logic       mem_write_en_o, mem_read_en_o;
  logic [3:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [1:0] dbg_state;

  // Memory seen by the DUT, updated only from the DUT's memory outputs.
  logic [3:0] sim_mem [16];
  // Reference model state.
  logic [3:0] ref_mem [16];
  int         m_owner;
  int         m_last;
  logic [1:0] m_rv;
  logic [3:0] m_rd [2];
  logic [4:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .req0_i         (req[0]),
    .we0_i          (we[0]),
    .lock0_i        (lock[0]),
    .addr0_i        (addr[0]),
    .wdata0_i       (wdata[0]),
    .gnt0_o         (gnt0_o),
    .rvalid0_o      (rvalid0_o),
    .rdata0_o       (rdata0_o),
    .req1_i         (req[1]),
    .we1_i          (we[1]),
    .lock1_i        (lock[1]),
    .addr1_i        (addr[1]),
    .wdata1_i       (wdata[1]),
    .gnt1_o         (gnt1_o),
    .rvalid1_o      (rvalid1_o),
    .rdata1_o       (rdata1_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_read_en_o  (mem_read_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .dbg_state_o    (dbg_state)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_i = sim_mem[mem_addr_o];

  always @(posedge clk) begin
    if (mem_write_en_o) sim_mem[mem_addr_o] <= mem_data_o;
  end

  // Which port the rules say wins this cycle (-1 = none).
  function automatic int exp_winner();
    if (!rst_n) return -1;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  // Advance one clock and move the reference model across the edge.
  task automatic tick();
    int w;
    w = exp_winner();
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 1;
      m_rv    = 2'b00;
      m_rd[0] = 4'h0;
      m_rd[1] = 4'h0;
      exp_q.delete();
    end else begin
      m_rv = 2'b00;
      if (w >= 0) begin
        m_last  = w;
        m_owner = lock[w] ? w : -1;
        if (we[w]) begin
          ref_mem[addr[w]] = wdata[w];
        end else begin
          m_rv[w] = 1'b1;
          m_rd[w] = ref_mem[addr[w]];
          exp_q.push_back({w[0], ref_mem[addr[w]]});
        end
      end else if (m_owner >= 0 && !lock[m_owner]) begin
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; lock = 2'b00;
    addr[0] = 4'h0; addr[1] = 4'h0; wdata[0] = 4'h0; wdata[1] = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b11; we = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if ({gnt1_o, gnt0_o, mem_write_en_o, mem_read_en_o} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_gnt_mem: got gnt=%b%b we=%b re=%b, want all 0",
                 gnt1_o, gnt0_o, mem_write_en_o, mem_read_en_o);
      end
      tick();
    end
    #2;
    checks++;
    if ({rvalid1_o, rvalid0_o, rdata1_o, rdata0_o} !== 10'h0) begin
      errors++;
      $display("FAIL reset_read_regs: got rvalid=%b%b rdata1=%h rdata0=%h, want 0",
               rvalid1_o, rvalid0_o, rdata1_o, rdata0_o);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'h3;
    #2;
    checks++;
    if ({gnt0_o, gnt1_o, mem_read_en_o, mem_write_en_o, mem_addr_o} !== {4'b1010, 4'h3}) begin
      errors++;
      $display("FAIL single_read_grant: got gnt0=%b gnt1=%b re=%b we=%b addr=%h, want 1 0 1 0 3",
               gnt0_o, gnt1_o, mem_read_en_o, mem_write_en_o, mem_addr_o);
    end
    tick();
    req[0] = 1'b0;
    #2;
    checks++;
    if ({rvalid0_o, rdata0_o} !== {1'b1, 4'h7}) begin
      errors++;
      $display("FAIL single_read_data: got rvalid0=%b rdata0=%h, want 1 7", rvalid0_o, rdata0_o);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    #2;
    checks++;
    if ({rvalid0_o, rdata0_o} !== {1'b0, 4'h7}) begin
      errors++;
      $display("FAIL single_read_hold: got rvalid0=%b rdata0=%h, want 0 7", rvalid0_o, rdata0_o);
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11; we = 2'b11; lock = 2'b00;
    for (int i = 0; i < 6; i++) begin
      addr[0]  = 4'($urandom_range(0, 15));
      addr[1]  = 4'($urandom_range(0, 15));
      wdata[0] = 4'($urandom_range(0, 15));
      wdata[1] = 4'($urandom_range(0, 15));
      #2;
      checks++;
      if ({gnt1_o, gnt0_o} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_seq[%0d]: got gnt1/gnt0=%b%b, want port %0d", i, gnt1_o, gnt0_o, i % 2);
      end
      checks++;
      if (mem_addr_o !== addr[i % 2] || mem_data_o !== wdata[i % 2]) begin
        errors++;
        $display("FAIL contention_addr[%0d]: got addr=%h data=%h, want %h %h",
                 i, mem_addr_o, mem_data_o, addr[i % 2], wdata[i % 2]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_loader_burst();
    logic [3:0] words [3];
    words[0] = 4'hE; words[1] = 4'h5; words[2] = 4'hA;
    for (int i = 0; i < 3; i++) begin
      req[1] = 1'b1; we[1] = 1'b1; lock[1] = (i != 2);
      addr[1] = 4'(i); wdata[1] = words[i];
      #2;
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b10) begin
        errors++;
        $display("FAIL burst_word[%0d]: got gnt1/gnt0=%b%b, want 10", i, gnt1_o, gnt0_o);
      end
      tick();
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'h5; wdata[0] = 4'h9;
    end
    req[1] = 1'b0; lock[1] = 1'b0;
    #2;
    checks++;
    if ({gnt1_o, gnt0_o} !== 2'b01) begin
      errors++;
      $display("FAIL burst_release: got gnt1/gnt0=%b%b, want 01", gnt1_o, gnt0_o);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if ({sim_mem[0], sim_mem[1], sim_mem[2]} !== 12'hE5A) begin
      errors++;
      $display("FAIL burst_mem: got %h%h%h, want E5A", sim_mem[0], sim_mem[1], sim_mem[2]);
    end
  endtask

  task automatic test_locked_idle();
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'hC; wdata[1] = 4'h3;
    #2;
    checks++;
    if ({gnt1_o, gnt0_o} !== 2'b10) begin
      errors++;
      $display("FAIL lock_take: got gnt1/gnt0=%b%b, want 10", gnt1_o, gnt0_o);
    end
    tick();
    req[1] = 1'b0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'hD; wdata[0] = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b00) begin
        errors++;
        $display("FAIL lock_stall[%0d]: got gnt1/gnt0=%b%b, want 00", i, gnt1_o, gnt0_o);
      end
      tick();
    end
    lock[1] = 1'b0;
    #2;
    checks++;
    if (gnt0_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_drop_cycle: got gnt0=%b, want 0", gnt0_o);
    end
    tick();
    #2;
    checks++;
    if ({gnt1_o, gnt0_o} !== 2'b01) begin
      errors++;
      $display("FAIL lock_after_release: got gnt1/gnt0=%b%b, want 01", gnt1_o, gnt0_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'h1;
    #2;
    checks++;
    if (gnt1_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: got gnt1=%b, want 1", gnt1_o);
    end
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({gnt1_o, gnt0_o, rvalid1_o} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_forced: got gnt1=%b gnt0=%b rvalid1=%b, want 0 0 1",
               gnt1_o, gnt0_o, rvalid1_o);
    end
    tick();
    #2;
    checks++;
    if (rvalid1_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rvalid: got rvalid1=%b, want 0", rvalid1_o);
    end
    rst_n = 1'b1;
    req = 2'b11; we = 2'b11; lock = 2'b00;
    #2;
    checks++;
    if ({gnt1_o, gnt0_o} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first_tie: got gnt1/gnt0=%b%b, want 01", gnt1_o, gnt0_o);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [1:0] pending;
    logic [1:0] eg;
    logic [3:0] e_addr, e_data;
    logic       e_we, e_re;
    logic [4:0] e;
    int         w;
    pending = 2'b00;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pending[k]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[k] = 1'b1; pending[k] = 1'b1;
            we[k] = 1'($urandom_range(0, 1));
          end else begin
            req[k] = 1'b0;
            we[k] = 1'($urandom_range(0, 1));
          end
          addr[k]  = 4'($urandom_range(0, 15));
          wdata[k] = 4'($urandom_range(0, 15));
        end
        lock[k] = ($urandom_range(0, 3) == 0);
      end
      #2;
      w      = exp_winner();
      eg     = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
      e_addr = (w >= 0) ? addr[w] : 4'h0;
      e_data = (w >= 0) ? wdata[w] : 4'h0;
      e_we   = (w >= 0) && we[w];
      e_re   = (w >= 0) && !we[w];
      checks++;
      if ({gnt1_o, gnt0_o} !== eg) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b%b, want %b", n, gnt1_o, gnt0_o, eg);
      end
      checks++;
      if ({mem_write_en_o, mem_read_en_o, mem_addr_o, mem_data_o} !== {e_we, e_re, e_addr, e_data}) begin
        errors++;
        $display("FAIL rand_mem[%0d]: got we=%b re=%b a=%h d=%h, want %b %b %h %h", n,
                 mem_write_en_o, mem_read_en_o, mem_addr_o, mem_data_o, e_we, e_re, e_addr, e_data);
      end
      checks++;
      if ({rvalid1_o, rvalid0_o} !== m_rv) begin
        errors++;
        $display("FAIL rand_rvalid[%0d]: got %b%b, want %b", n, rvalid1_o, rvalid0_o, m_rv);
      end
      for (int k = 0; k < 2; k++) begin
        if (m_rv[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_queue[%0d]: expected read entry missing for port %0d", n, k);
          end else begin
            e = exp_q.pop_front();
            if (e[4] !== 1'(k) || (k == 0 ? rdata0_o : rdata1_o) !== e[3:0]) begin
              errors++;
              $display("FAIL rand_rdata[%0d]: port %0d got %h, want port %0d data %h",
                       n, k, (k == 0 ? rdata0_o : rdata1_o), e[4], e[3:0]);
            end
          end
        end
      end
      checks++;
      if (rdata0_o !== m_rd[0] || rdata1_o !== m_rd[1]) begin
        errors++;
        $display("FAIL rand_rdata_hold[%0d]: got %h %h, want %h %h", n, rdata0_o, rdata1_o, m_rd[0], m_rd[1]);
      end
      tick();
      if (w >= 0) pending[w] = 1'b0;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sim_mem[i] = 4'(i * 5 + 1);
      ref_mem[i] = 4'(i * 5 + 1);
    end
    sim_mem[3] = 4'h7;
    ref_mem[3] = 4'h7;
    m_owner = -1; m_last = 1; m_rv = 2'b00; m_rd[0] = 4'h0; m_rd[1] = 4'h0;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_loader_burst();
    test_locked_idle();
    test_reset_mid_burst();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
